// File: rtl/axis_arb_pkg.sv
// axis_arb_pkg: FSM encoding and sizing helpers shared by the AXIS frame arbiter and its selector.
package axis_arb_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} arb_state_t;
    localparam int IDX_W   = 2;
    localparam int MAX_SRC = 4;
    function automatic int beat_cnt_w(input int max_beats);
        return $clog2(max_beats + 1);
    endfunction
endpackage

// File: rtl/axis_frame_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector; the search starts one past i_last and wraps.
module rr_pick
    import axis_arb_pkg::*;
#(
    parameter int NUM_SRC = 2
)(
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [NUM_SRC-1:0] i_mask,
    input  logic [IDX_W-1:0]   i_last,
    output logic [IDX_W-1:0]   o_grant,
    output logic               o_valid
);
    logic [MAX_SRC-1:0] w_elig;
    logic [IDX_W-1:0]   w_idx;
    assign w_elig = MAX_SRC'(i_req & i_mask);
    // Scan farthest candidate first so the nearest eligible source is the one left standing.
    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        w_idx   = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            w_idx = IDX_W'((int'(i_last) + k) % NUM_SRC);
            if (w_elig[w_idx]) begin
                o_grant = w_idx;
                o_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/axis_frame_arbiter.sv
// axis_frame_arbiter: merges NUM_SRC packetized AXI-Stream sources onto one DMA stream,
// whole frames at a time, with round-robin fairness and a hard per-frame beat limit.
module axis_frame_arbiter
    import axis_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = 1,
    parameter int NUM_SRC    = 2,
    parameter int MAX_BEATS  = 512,
    parameter int CNT_WIDTH  = 16
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0]            s_axis_tvalid,
    output logic [NUM_SRC-1:0]            s_axis_tready,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]            s_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
    output logic                          m_axis_tlast,
    output logic [1:0]                    m_axis_tdest,
    input  logic [NUM_SRC-1:0]            src_enable,
    output logic [NUM_SRC*CNT_WIDTH-1:0]  frame_cnt,
    output logic [NUM_SRC-1:0]            overflow,
    output logic                          busy
);
    localparam int                BEAT_W    = beat_cnt_w(MAX_BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BEATS - 1);

    arb_state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0]     r_grant, r_last_grant, w_pick;
    logic                 w_pick_valid;
    logic [BEAT_W-1:0]    r_beat;
    logic [CNT_WIDTH-1:0] r_frame_cnt [NUM_SRC];
    logic [NUM_SRC-1:0]   r_overflow;
    logic [MAX_SRC-1:0]   w_valid4, w_last4;
    logic [DATA_WIDTH-1:0] w_data [MAX_SRC];
    logic w_src_valid, w_src_last, w_at_limit, w_eff_last, w_hs, w_done, w_force;

    assign w_valid4 = MAX_SRC'(s_axis_tvalid);
    assign w_last4  = MAX_SRC'(s_axis_tlast);

    for (genvar g = 0; g < MAX_SRC; g++) begin : g_data
        if (g < NUM_SRC) begin : g_used
            assign w_data[g] = s_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_unused
            assign w_data[g] = '0;
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_cnt
        assign frame_cnt[g*CNT_WIDTH +: CNT_WIDTH] = r_frame_cnt[g];
    end

    assign overflow = r_overflow;

    rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
        .i_req   (s_axis_tvalid),
        .i_mask  (src_enable),
        .i_last  (r_last_grant),
        .o_grant (w_pick),
        .o_valid (w_pick_valid)
    );

    // The beat limit overrides a missing source tlast; the remainder becomes the next frame.
    assign w_src_valid = w_valid4[r_grant];
    assign w_src_last  = w_last4[r_grant];
    assign w_at_limit  = r_beat == LAST_BEAT;
    assign w_eff_last  = w_src_last | w_at_limit;
    assign w_hs        = (r_state == ST_GRANT) & w_src_valid & m_axis_tready;
    assign w_done      = w_hs & w_eff_last;
    assign w_force     = w_hs & w_at_limit & ~w_src_last;

    always_ff @(posedge clk) r_state <= rst ? ST_IDLE : w_state_nxt;

    always_comb begin
        w_state_nxt = (r_state == ST_IDLE) ? (w_pick_valid ? ST_GRANT : ST_IDLE)
                                           : (w_done ? ST_IDLE : ST_GRANT);
    end

    always_comb begin
        busy          = r_state == ST_GRANT;
        m_axis_tvalid = busy & w_src_valid;
        m_axis_tdata  = busy ? w_data[r_grant] : '0;
        m_axis_tlast  = busy & w_eff_last;
        m_axis_tdest  = r_grant;
        m_axis_tkeep  = '1;
        s_axis_tready = '0;
        for (int i = 0; i < NUM_SRC; i++)
            s_axis_tready[i] = busy & m_axis_tready & (r_grant == IDX_W'(i));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant      <= '0;
            r_last_grant <= IDX_W'(NUM_SRC - 1);
            r_beat       <= '0;
            r_overflow   <= '0;
            for (int i = 0; i < NUM_SRC; i++) r_frame_cnt[i] <= '0;
        end else begin
            if (r_state == ST_IDLE && w_pick_valid) r_grant <= w_pick;
            if (w_hs) r_beat <= w_eff_last ? '0 : r_beat + BEAT_W'(1);
            if (w_done) r_last_grant <= r_grant;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (w_done && r_grant == IDX_W'(i)) r_frame_cnt[i] <= r_frame_cnt[i] + CNT_WIDTH'(1);
                if (w_force && r_grant == IDX_W'(i)) r_overflow[i] <= 1'b1;
            end
        end
    end
endmodule
